alu_seq_core: RTL and testbench

Parametrised, single-clock successor to the board-level ALU. Operand A, operand B and the opcode load from one shared `din` bus under per-register load buttons. Operations run on explicit start, with a busy/done handshake. Shifts and multiply run serially over several cycles. Results and the ZF/CF/OF/SF flags stay registered until the next completed operation. The block sits between the switch/button front end and the display driver.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/edge_det.sv | 20 ++
 rtl/alu_seq_core.sv | 162 ++++++++++++++++
 tb/tb_alu_seq_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_MUL,
        ST_DONE
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/edge_det.sv
// One-bit rising-edge detector; history resets high so a button held through reset never fires.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic hist;

    always_ff @(posedge clk) begin
        if (rst)
            hist <= 1'b1;
        else
            hist <= sig;
    end

    assign rise = sig & ~hist;

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU: button-loaded operands, start/busy/done handshake,
// single-cycle logic ops plus serial shift and shift-add multiply.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_op,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    logic rise_a, rise_b, rise_op, rise_start;

    edge_det u_ed_a     (.clk(clk), .rst(rst), .sig(ld_a),  .rise(rise_a));
    edge_det u_ed_b     (.clk(clk), .rst(rst), .sig(ld_b),  .rise(rise_b));
    edge_det u_ed_op    (.clk(clk), .rst(rst), .sig(ld_op), .rise(rise_op));
    edge_det u_ed_start (.clk(clk), .rst(rst), .sig(start), .rise(rise_start));

    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_w, b_w, acc;
    logic [3:0]       op_w;
    logic [SHW:0]     cnt;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res, shift_next;
    logic             alu_cf, alu_of;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic cf, input logic of);
        logic [3:0] f;
        f          = '0;
        f[FLAG_ZF] = (r == '0);
        f[FLAG_CF] = cf;
        f[FLAG_OF] = of;
        f[FLAG_SF] = r[WIDTH-1];
        return f;
    endfunction

    // Operates on the copies taken at start, so a coincident load cannot leak into the result
    always_comb begin
        sum     = {1'b0, a_w} + {1'b0, b_w};
        diff    = {1'b0, a_w} - {1'b0, b_w};
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
        case (op_w)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = sum[WIDTH];
                alu_of  = (a_w[WIDTH-1] == b_w[WIDTH-1]) && (sum[WIDTH-1] != a_w[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_cf  = diff[WIDTH];
                alu_of  = (a_w[WIDTH-1] != b_w[WIDTH-1]) && (diff[WIDTH-1] != a_w[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_w) < $signed(b_w)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a_w < b_w};
            OP_XOR:  alu_res = a_w ^ b_w;
            OP_OR:   alu_res = a_w | b_w;
            OP_AND:  alu_res = a_w & b_w;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (op_w)
            OP_SLL:  shift_next = a_w << 1;
            OP_SRL:  shift_next = a_w >> 1;
            default: shift_next = {a_w[WIDTH-1], a_w[WIDTH-1:1]};
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Operand registers only accept loads in IDLE; done is a registered one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            a_w    <= '0;
            b_w    <= '0;
            op_w   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise_a)  a_reg  <= din;
                    if (rise_b)  b_reg  <= din;
                    if (rise_op) op_reg <= din[3:0];
                    if (rise_start) begin
                        op_w <= op_reg;
                        a_w  <= a_reg;
                        b_w  <= b_reg;
                        if (is_shift(op_reg)) begin
                            cnt   <= {1'b0, b_reg[SHW-1:0]};
                            state <= ST_SHIFT;
                        end else if (op_reg == OP_MUL) begin
                            cnt   <= (SHW+1)'(WIDTH);
                            acc   <= '0;
                            state <= ST_MUL;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    result <= alu_res;
                    flags  <= mk_flags(alu_res, alu_cf, alu_of);
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        result <= a_w;
                        flags  <= mk_flags(a_w, 1'b0, 1'b0);
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        a_w <= shift_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_MUL: begin
                    if (cnt == '0) begin
                        result <= acc;
                        flags  <= mk_flags(acc, 1'b0, 1'b0);
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        if (b_w[0]) acc <= acc + a_w;
                        a_w <= a_w << 1;
                        b_w <= b_w >> 1;
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core: a 32-bit instance for the ALU ops and
// an 8-bit instance for multiply, frozen operands and reset abort.
module tb_alu_seq_core;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, ld_a32, ld_b32, ld_op32, start32;
    logic [31:0] din32, result32;
    logic [3:0]  flags32;
    logic        busy32, done32;

    logic        rst8, ld_a8, ld_b8, ld_op8, start8;
    logic [7:0]  din8, result8;
    logic [3:0]  flags8;
    logic        busy8, done8;

    int checks = 0;
    int errors = 0;

    alu_seq_core #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst32), .din(din32), .ld_a(ld_a32), .ld_b(ld_b32),
        .ld_op(ld_op32), .start(start32), .result(result32), .flags(flags32),
        .busy(busy32), .done(done32)
    );

    alu_seq_core #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .din(din8), .ld_a(ld_a8), .ld_b(ld_b8),
        .ld_op(ld_op8), .start(start8), .result(result8), .flags(flags8),
        .busy(busy8), .done(done8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // btn: 0 = A, 1 = B, 2 = OP; one press of one button on one instance
    task automatic applyStimulus(input int sel, input int btn, input logic [31:0] val);
        @(negedge clk);
        if (sel == 0) begin
            din32 = val;
            case (btn)
                0:       ld_a32  = 1'b1;
                1:       ld_b32  = 1'b1;
                default: ld_op32 = 1'b1;
            endcase
        end else begin
            din8 = val[7:0];
            case (btn)
                0:       ld_a8  = 1'b1;
                1:       ld_b8  = 1'b1;
                default: ld_op8 = 1'b1;
            endcase
        end
        @(negedge clk);
        ld_a32 = 1'b0; ld_b32 = 1'b0; ld_op32 = 1'b0;
        ld_a8  = 1'b0; ld_b8  = 1'b0; ld_op8  = 1'b0;
    endtask

    // lat counts edges after N until done is seen
    task automatic launch(input int sel, input int limit, input bit with_ld_a,
                          input logic [31:0] ld_val, output int lat);
        bit found;
        @(negedge clk);
        if (sel == 0) begin
            start32 = 1'b1;
            if (with_ld_a) begin din32 = ld_val; ld_a32 = 1'b1; end
        end else begin
            start8 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0; start8 = 1'b0; ld_a32 = 1'b0;
        checkOutput("busy_after_n", (sel != 0) ? busy8 : busy32, 1'b1);
        lat   = 0;
        found = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (((sel != 0) ? done8 : done32) == 1'b1) begin
                lat   = i;
                found = 1'b1;
                break;
            end
        end
        if (!found) checkOutput("done_timeout", 1'b0, 1'b1);
        checkOutput("busy_in_done", (sel != 0) ? busy8 : busy32, 1'b1);
        @(negedge clk);
        checkOutput("done_one_cycle", (sel != 0) ? done8 : done32, 1'b0);
        checkOutput("idle_after_done", (sel != 0) ? busy8 : busy32, 1'b0);
    endtask

    task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic [3:0] exp_flags, input int exp_lat);
        int lat;
        applyStimulus(0, 0, a);
        applyStimulus(0, 1, b);
        applyStimulus(0, 2, {28'b0, op});
        launch(0, exp_lat + 5, 1'b0, 32'h0, lat);
        checkOutput({tag, "_res"}, result32, exp_res);
        checkOutput({tag, "_flags"}, flags32, exp_flags);
        checkOutput({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        int  lat, pulses;
        bit  found, seen;

        rst32 = 1'b1; rst8 = 1'b1;
        din32 = '0; din8 = '0;
        ld_a32 = 0; ld_b32 = 0; ld_op32 = 0; start32 = 0;
        ld_a8  = 0; ld_b8  = 0; ld_op8  = 0; start8  = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst32 = 1'b0; rst8 = 1'b0;

        checkOutput("rst_result", result32, 32'h0);
        checkOutput("rst_flags", flags32, 4'b0000);
        checkOutput("rst_busy", busy32, 1'b0);
        checkOutput("rst_done", done32, 1'b0);
        checkOutput("rst_result8", result8, 8'h0);

        run32("add_ovf",  OP_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0101, 1);
        run32("add",      OP_ADD,  32'h1,        32'h1,        32'h2,        4'b0000, 1);
        run32("sub",      OP_SUB,  32'h1,        32'h2,        32'hFFFFFFFF, 4'b0101, 1);
        run32("add_sovf", OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0011, 1);
        run32("sub_zero", OP_SUB,  32'h5,        32'h5,        32'h0,        4'b1000, 1);
        run32("sll",      OP_SLL,  32'h1,        32'h2,        32'h4,        4'b0000, 3);
        run32("sra",      OP_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 4'b0001, 32);
        run32("srl",      OP_SRL,  32'h80000000, 32'd4,        32'h08000000, 4'b0000, 5);
        run32("slt_neg",  OP_SLT,  32'hA0000001, 32'h1,        32'h1,        4'b0000, 1);
        run32("sltu",     OP_SLTU, 32'hA0000001, 32'h1,        32'h0,        4'b1000, 1);
        run32("slt_pos",  OP_SLT,  32'h2,        32'h1,        32'h0,        4'b1000, 1);
        run32("xor",      OP_XOR,  32'hF0F0,     32'hFF00,     32'h0FF0,     4'b0000, 1);
        run32("or",       OP_OR,   32'hF0F0,     32'hFF00,     32'hFFF0,     4'b0000, 1);
        run32("and",      OP_AND,  32'hF0F0,     32'hFF00,     32'hF000,     4'b0000, 1);
        run32("undef",    4'b1111, 32'h1234,     32'h5678,     32'h0,        4'b1000, 1);

        // Load coinciding with start: op sees old A, new A is kept for the next op
        applyStimulus(0, 0, 32'd5);
        applyStimulus(0, 1, 32'd3);
        applyStimulus(0, 2, {28'b0, OP_ADD});
        launch(0, 6, 1'b1, 32'd100, lat);
        checkOutput("simul_old_a", result32, 32'd8);
        launch(0, 6, 1'b0, 32'h0, lat);
        checkOutput("simul_new_a", result32, 32'd103);

        // Second start while a 4-step shift is running must be dropped
        applyStimulus(0, 0, 32'h1);
        applyStimulus(0, 1, 32'd4);
        applyStimulus(0, 2, {28'b0, OP_SLL});
        @(negedge clk); start32 = 1'b1;
        @(posedge clk);
        @(negedge clk); start32 = 1'b0;
        @(negedge clk); start32 = 1'b1;
        @(negedge clk); start32 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done32) pulses++;
        end
        checkOutput("start_dropped", pulses, 1);
        checkOutput("sll4_res", result32, 32'h10);

        applyStimulus(0, 0, 32'hDEAD);
        repeat (3) @(negedge clk);
        checkOutput("result_hold", result32, 32'h10);

        // 8-bit multiply
        applyStimulus(1, 0, 32'h0F);
        applyStimulus(1, 1, 32'h11);
        applyStimulus(1, 2, {28'b0, OP_MUL});
        launch(1, 15, 1'b0, 32'h0, lat);
        checkOutput("mul_res", result8, 8'hFF);
        checkOutput("mul_flags", flags8, 4'b0001);
        checkOutput("mul_lat", lat, 9);

        // Load A while busy must not change A
        @(negedge clk); start8 = 1'b1;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0; din8 = 8'h01; ld_a8 = 1'b1;
        @(negedge clk); ld_a8 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin found = 1'b1; break; end
        end
        checkOutput("mul2_done", found, 1'b1);
        checkOutput("a_frozen", result8, 8'hFF);
        repeat (2) @(negedge clk);

        // Reset at N+4 aborts; start held through reset must not fire
        @(negedge clk); start8 = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", busy8, 1'b0);
        checkOutput("abort_done", done8, 1'b0);
        checkOutput("abort_result", result8, 8'h00);
        rst8 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy8 || done8) seen = 1'b1;
        end
        checkOutput("held_start_quiet", seen, 1'b0);
        start8 = 1'b0;

        // After release, a fresh press runs ADD on reset operands
        launch(1, 6, 1'b0, 32'h0, lat);
        checkOutput("post_rst_res", result8, 8'h00);
        checkOutput("post_rst_flags", flags8, 4'b1000);
        checkOutput("post_rst_lat", lat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
